branch_predict_unit: RTL and testbench

//  Branch resolution plus bimodal prediction for the pipelined CPU. Resolves EX-stage branches of
//  six condition types from ALU zero/sign flags and flags mispredictions for IF/ID flush. Keeps a

---
 rtl/branch_pkg.sv | 30 +++
 rtl/branch_cond_eval.sv | 28 ++
 rtl/branch_predict_unit.sv | 96 +++++++++
 tb/tb_branch_predict_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared encodings for branch resolution and bimodal prediction.
// Branch types, 2-bit counter states and the counter update helper.
package branch_pkg;

    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_BLEZ = 3'd5;
    localparam logic [2:0] BR_BGTZ = 3'd6;
    localparam logic [2:0] BR_RSVD = 3'd7;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] CNT_RESET = WNT;

    // Saturating step of a 2-bit counter toward the resolved direction.
    function automatic logic [1:0] cnt_next(input logic [1:0] c,
                                            input logic       taken);
        if (taken)
            return (c == ST) ? ST : c + 2'd1;
        else
            return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition evaluator: type plus ALU flags to taken.
// Reserved type 7 behaves like NONE (not a branch).
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] branch_type_i,
    input  logic       zero_i,
    input  logic       result_31_i,
    output logic       taken_o,
    output logic       is_branch_o
);

    // Decode the condition for each branch type.
    always_comb begin
        taken_o     = 1'b0;
        is_branch_o = 1'b1;
        unique case (branch_type_i)
            BR_BEQ:  taken_o = zero_i;
            BR_BNE:  taken_o = !zero_i;
            BR_BLT:  taken_o = result_31_i;
            BR_BGE:  taken_o = !result_31_i;
            BR_BLEZ: taken_o = zero_i | result_31_i;
            BR_BGTZ: taken_o = !zero_i & !result_31_i;
            default: is_branch_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution and bimodal predictor with 2-bit counters.
// Optional statistics counters: define BRANCH_PRED_STATS_EN.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int IDX_W     = 4,
    parameter int PC_W      = 32,
    parameter int PRED_MODE = 1,
    parameter int STAT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [PC_W-1:0]   if_pc_i,
    output logic              if_pred_taken_o,
    input  logic              ex_valid_i,
    input  logic [2:0]        ex_branch_type_i,
    input  logic              ex_zero_i,
    input  logic              ex_result_31_i,
    input  logic [PC_W-1:0]   ex_pc_i,
    input  logic              ex_pred_taken_i,
    output logic              ex_taken_o,
    output logic              ex_mispredict_o,
    output logic [STAT_W-1:0] stat_branches_o,
    output logic [STAT_W-1:0] stat_mispred_o
);

    localparam int N = 1 << IDX_W;

    logic             cond_taken;
    logic             is_br;
    logic             upd_en;
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             unused_pc;

    branch_cond_eval u_cond (
        .branch_type_i (ex_branch_type_i),
        .zero_i        (ex_zero_i),
        .result_31_i   (ex_result_31_i),
        .taken_o       (cond_taken),
        .is_branch_o   (is_br)
    );

    assign upd_en          = ex_valid_i & is_br;
    assign ex_taken_o      = upd_en & cond_taken;
    assign ex_mispredict_o = upd_en & (cond_taken != ex_pred_taken_i);

    assign if_idx    = if_pc_i[IDX_W+1:2];
    assign ex_idx    = ex_pc_i[IDX_W+1:2];
    assign unused_pc = ^{if_pc_i, ex_pc_i, if_idx, ex_idx};

    generate
        if (PRED_MODE != 0) begin : g_bimodal
            logic [1:0] cnt_q [N];

            // Counter table: reset to weakly not-taken, else train on resolve.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < N; i++)
                        cnt_q[i] <= CNT_RESET;
                end else if (upd_en) begin
                    cnt_q[ex_idx] <= cnt_next(cnt_q[ex_idx], cond_taken);
                end
            end

            assign if_pred_taken_o = cnt_q[if_idx][1];
        end else begin : g_static
            assign if_pred_taken_o = 1'b0;
        end
    endgenerate

`ifdef BRANCH_PRED_STATS_EN
    logic [STAT_W-1:0] br_q;
    logic [STAT_W-1:0] mp_q;

    // Saturating counts of resolved branches and mispredictions.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_q <= '0;
            mp_q <= '0;
        end else if (upd_en) begin
            if (br_q != '1)
                br_q <= br_q + 1'b1;
            if (ex_mispredict_o && mp_q != '1)
                mp_q <= mp_q + 1'b1;
        end
    end

    assign stat_branches_o = br_q;
    assign stat_mispred_o  = mp_q;
`else
    assign stat_branches_o = '0;
    assign stat_mispred_o  = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit (bimodal and static).
// Table-driven vectors with a queue scoreboard and a small counter model.
module tb_branch_predict_unit;
    import branch_pkg::*;

    localparam int IDX_W  = 4;
    localparam int PC_W   = 32;
    localparam int STAT_W = 16;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [PC_W-1:0]   if_pc_i;
    logic              ex_valid_i;
    logic [2:0]        ex_branch_type_i;
    logic              ex_zero_i;
    logic              ex_result_31_i;
    logic [PC_W-1:0]   ex_pc_i;
    logic              ex_pred_taken_i;

    logic              pred1, taken1, misp1;
    logic [STAT_W-1:0] sb1, sm1;
    logic              pred0, taken0, misp0;
    logic [STAT_W-1:0] sb0, sm0;

    always #5 clk = ~clk;

    branch_predict_unit #(
        .IDX_W(IDX_W), .PC_W(PC_W), .PRED_MODE(1), .STAT_W(STAT_W)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .if_pc_i         (if_pc_i),
        .if_pred_taken_o (pred1),
        .ex_valid_i      (ex_valid_i),
        .ex_branch_type_i(ex_branch_type_i),
        .ex_zero_i       (ex_zero_i),
        .ex_result_31_i  (ex_result_31_i),
        .ex_pc_i         (ex_pc_i),
        .ex_pred_taken_i (ex_pred_taken_i),
        .ex_taken_o      (taken1),
        .ex_mispredict_o (misp1),
        .stat_branches_o (sb1),
        .stat_mispred_o  (sm1)
    );

    branch_predict_unit #(
        .IDX_W(IDX_W), .PC_W(PC_W), .PRED_MODE(0), .STAT_W(STAT_W)
    ) dut0 (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .if_pc_i         (if_pc_i),
        .if_pred_taken_o (pred0),
        .ex_valid_i      (ex_valid_i),
        .ex_branch_type_i(ex_branch_type_i),
        .ex_zero_i       (ex_zero_i),
        .ex_result_31_i  (ex_result_31_i),
        .ex_pc_i         (ex_pc_i),
        .ex_pred_taken_i (ex_pred_taken_i),
        .ex_taken_o      (taken0),
        .ex_mispredict_o (misp0),
        .stat_branches_o (sb0),
        .stat_mispred_o  (sm0)
    );

    typedef struct {
        logic        vld;
        logic [2:0]  typ;
        logic        z;
        logic        r;
        logic [31:0] pc;
        logic        pin;
        logic [31:0] lk;
        logic        et;
        logic        em;
    } vec_t;

    typedef struct {
        logic        et;
        logic        em;
        logic        ep;
        logic [15:0] sb;
        logic [15:0] sm;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb_q[$];
    logic [1:0]  mdl [16];
    logic [15:0] m_br;
    logic [15:0] m_mp;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic vec_t mk(logic vld, logic [2:0] typ, logic z,
                                logic r, logic [31:0] pc, logic pin,
                                logic [31:0] lk, logic et, logic em);
        vec_t v;
        v.vld = vld; v.typ = typ; v.z = z; v.r = r; v.pc = pc;
        v.pin = pin; v.lk = lk; v.et = et; v.em = em;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl[i] = WNT;
        m_br = '0;
        m_mp = '0;
    endtask

    task automatic drive(vec_t v, logic rst, string tag);
        exp_t e;
        exp_t g;
        int   li;
        int   ui;
        rst_i            = rst;
        ex_valid_i       = v.vld;
        ex_branch_type_i = v.typ;
        ex_zero_i        = v.z;
        ex_result_31_i   = v.r;
        ex_pc_i          = v.pc;
        ex_pred_taken_i  = v.pin;
        if_pc_i          = v.lk;
        li   = int'(v.lk[5:2]);
        e.et = v.et;
        e.em = v.em;
        e.ep = mdl[li][1];
`ifdef BRANCH_PRED_STATS_EN
        e.sb = m_br;
        e.sm = m_mp;
`else
        e.sb = '0;
        e.sm = '0;
`endif
        sb_q.push_back(e);
        @(negedge clk);
        g = sb_q.pop_front();
        chk({tag, " taken"},    32'(taken1), 32'(g.et));
        chk({tag, " misp"},     32'(misp1),  32'(g.em));
        chk({tag, " pred"},     32'(pred1),  32'(g.ep));
        chk({tag, " stat_br"},  32'(sb1),    32'(g.sb));
        chk({tag, " stat_mp"},  32'(sm1),    32'(g.sm));
        chk({tag, " s0 pred"},  32'(pred0),  32'(0));
        chk({tag, " s0 taken"}, 32'(taken0), 32'(g.et));
        chk({tag, " s0 misp"},  32'(misp0),  32'(g.em));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (v.vld && v.typ >= 3'd1 && v.typ <= 3'd6) begin
            ui = int'(v.pc[5:2]);
            if (v.et && mdl[ui] != ST)        mdl[ui] = mdl[ui] + 2'd1;
            else if (!v.et && mdl[ui] != SNT) mdl[ui] = mdl[ui] - 2'd1;
            m_br = m_br + 16'd1;
            if (v.em) m_mp = m_mp + 16'd1;
        end
        #1;
    endtask

    initial begin
        model_reset();
        rst_i = 1'b1; ex_valid_i = 1'b0; ex_branch_type_i = BR_NONE;
        ex_zero_i = 1'b0; ex_result_31_i = 1'b0; ex_pc_i = '0;
        ex_pred_taken_i = 1'b0; if_pc_i = '0;
        @(posedge clk);
        #1;

        // reset cycle with a taken update that must be dropped
        drive(mk(1, BR_BEQ, 1, 0, 32'h10, 0, 32'h10, 1, 1), 1'b1, "rst_upd");

        for (int i = 0; i < 16; i++)
            drive(mk(0, BR_NONE, 0, 0, 32'h0, 0, 32'(i * 4), 0, 0), 1'b0,
                  $sformatf("post_rst_pc%0h", i * 4));

        // training, aliasing, resolution sweep
        tbl.push_back(mk(1, BR_BEQ,  1, 0, 32'h10, 0, 32'h10, 1, 1));
        tbl.push_back(mk(1, BR_BEQ,  1, 0, 32'h10, 1, 32'h10, 1, 0));
        tbl.push_back(mk(1, BR_BEQ,  1, 0, 32'h10, 1, 32'h10, 1, 0));
        tbl.push_back(mk(1, BR_BEQ,  0, 0, 32'h10, 1, 32'h50, 0, 1));
        tbl.push_back(mk(1, BR_NONE, 1, 0, 32'h10, 0, 32'h10, 0, 0));
        tbl.push_back(mk(1, BR_BEQ,  0, 0, 32'h50, 1, 32'h10, 0, 1));
        tbl.push_back(mk(1, BR_NONE, 0, 0, 32'h50, 0, 32'h50, 0, 0));
        tbl.push_back(mk(1, BR_BLEZ, 0, 0, 32'h20, 0, 32'h20, 0, 0));
        tbl.push_back(mk(1, BR_BLEZ, 0, 1, 32'h20, 0, 32'h20, 1, 1));
        tbl.push_back(mk(1, BR_BLEZ, 1, 0, 32'h20, 0, 32'h20, 1, 1));
        tbl.push_back(mk(1, BR_BGTZ, 0, 0, 32'h20, 0, 32'h20, 1, 1));
        tbl.push_back(mk(1, BR_BGTZ, 0, 1, 32'h20, 0, 32'h20, 0, 0));
        tbl.push_back(mk(1, BR_BGTZ, 1, 0, 32'h20, 0, 32'h20, 0, 0));
        tbl.push_back(mk(1, BR_BLT,  0, 0, 32'h20, 0, 32'h20, 0, 0));
        tbl.push_back(mk(1, BR_BLT,  0, 1, 32'h20, 0, 32'h20, 1, 1));
        tbl.push_back(mk(1, BR_BLT,  1, 0, 32'h20, 0, 32'h20, 0, 0));
        tbl.push_back(mk(1, BR_BGE,  0, 1, 32'h20, 0, 32'h20, 0, 0));
        tbl.push_back(mk(1, BR_BGE,  0, 0, 32'h20, 0, 32'h20, 1, 1));
        tbl.push_back(mk(1, BR_BNE,  1, 0, 32'h20, 1, 32'h20, 0, 1));
        tbl.push_back(mk(1, BR_BNE,  0, 0, 32'h20, 0, 32'h20, 1, 1));
        tbl.push_back(mk(1, BR_RSVD, 1, 1, 32'h20, 1, 32'h20, 0, 0));
        tbl.push_back(mk(0, BR_BEQ,  1, 0, 32'h20, 1, 32'h20, 0, 0));
        tbl.push_back(mk(0, BR_NONE, 0, 0, 32'h20, 0, 32'h20, 0, 0));

        for (int i = 0; i < tbl.size(); i++)
            drive(tbl[i], 1'b0, $sformatf("vec%0d", i));

        // reset with a concurrent taken update clears table and stats
        drive(mk(1, BR_BEQ,  1, 0, 32'h20, 0, 32'h20, 1, 1), 1'b1, "rst2");
        drive(mk(0, BR_NONE, 0, 0, 32'h0,  0, 32'h20, 0, 0), 1'b0, "rst2_a");
        drive(mk(0, BR_NONE, 0, 0, 32'h0,  0, 32'h10, 0, 0), 1'b0, "rst2_b");

        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard: %0d left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
